serial_adder: RTL

- Bit-serial N-bit adder built around one full-adder bit cell and a carry flip-flop.
- Loads two operands on a start pulse and processes them LSB-first, one bit per clock.
- Presents the N-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of the gate-level full-adder cell and consumes its sum and carry outputs every cycle. It is the first sequential datapath stage in the adder family.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/fa_bit_cell.sv | 22 ++
 rtl/serial_adder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the serial adder family:
//   - SA_DEFAULT_WIDTH : default operand/sum width
//   - sa_state_e       : FSM state encoding (ST_IDLE=0, ST_RUN=1, ST_DONE=2)
//   - maj3()           : three-input majority, the carry function of a full adder
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// -----------------------------------------------------------------------------
// fa_bit_cell
// Combinational single-bit full adder.
// Ports:
//   a, b, cin : input bits
//   s         : sum bit   (a ^ b ^ cin)
//   c         : carry bit (majority of a, b, cin)
// -----------------------------------------------------------------------------
module fa_bit_cell
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial unsigned adder. Operands are captured on an accepted start and
// summed LSB-first, one bit per clock, through a single full-adder cell and a
// carry flop. The result is presented with a one-cycle done pulse and held
// until the next accepted start.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN): adds input `sub`; when set at
// load, B is inverted and the carry is preset to 1 so the block computes a-b
// (cout=1 means no borrow).
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : load request, honoured only while busy=0
//   a, b   : WIDTH-bit operands
//   cin    : carry-in
//   sub    : subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   : high while bits are being processed
//   done   : one-cycle result-valid pulse
//   sum    : WIDTH-bit result
//   cout   : final carry
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sa_state_e        state_r;
  sa_state_e        state_next_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_shift_s;
  logic [WIDTH-1:0] b_load_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cin_load_s;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             load_s;
  logic             last_s;
  logic             bit_s;
  logic             bit_c_s;

  fa_bit_cell u_fa (
    .a   (sa_r[0]),
    .b   (sb_r[0]),
    .cin (carry_r),
    .s   (bit_s),
    .c   (bit_c_s)
  );

  // Start is honoured in IDLE and DONE; the step on which cnt hits WIDTH-1 is the last.
  always_comb begin
    load_s = start && (state_r != ST_RUN);
    last_s = (state_r == ST_RUN) && (cnt_r == LAST_CNT);
  end

  // Operand B / carry values captured at load (inverted B and carry=1 when subtracting).
  always_comb begin
    b_load_s   = b;
    cin_load_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load_s   = ~b;
      cin_load_s = 1'b1;
    end else begin
      b_load_s   = b;
      cin_load_s = cin;
    end
`endif
  end

  // New sum bit enters at the MSB so that after WIDTH steps bit i sits at sum[i].
  always_comb begin
    sum_shift_s            = sum_r >> 1;
    sum_shift_s[WIDTH-1]   = bit_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (load_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Operand shift registers, carry flop, bit counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_r    <= '0;
      sb_r    <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
    end else if (load_s) begin
      sa_r    <= a;
      sb_r    <= b_load_s;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= cin_load_s;
      cout_r  <= 1'b0;
    end else if (state_r == ST_RUN) begin
      sa_r    <= sa_r >> 1;
      sb_r    <= sb_r >> 1;
      sum_r   <= sum_shift_s;
      cnt_r   <= cnt_r + CW'(1);
      carry_r <= bit_c_s;
      if (last_s) begin
        cout_r <= bit_c_s;
      end else begin
        cout_r <= cout_r;
      end
    end else begin
      sa_r    <= sa_r;
      sb_r    <= sb_r;
      sum_r   <= sum_r;
      cnt_r   <= cnt_r;
      carry_r <= carry_r;
      cout_r  <= cout_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule
